adc_frame_decoder: RTL and testbench

ADC_FRAME_DECODER -- requirements
Module: adc_frame_decoder

---
 rtl/adc_frame_decoder_pkg.sv | 38 +++
 rtl/adc_frame_decoder.sv | 113 +++++++++++
 tb/tb_adc_frame_decoder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_frame_decoder_pkg.sv
// Shared definitions for the ADC frame decoder: FSM state encoding,
// frame bit positions and the error counter width.
package adc_frame_decoder_pkg;

  // Decoder states: waiting for a header, or holding a header and waiting for its low byte
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  // Marker bit: 1 marks a header byte, 0 marks a low byte
  localparam int MARKER_BIT = 7;

  // Channel field inside the header byte
  localparam int CH_HI = 6;
  localparam int CH_LO = 3;
  localparam int CH_W  = CH_HI - CH_LO + 1;

  // Upper sample bits s[9:7] inside the header byte
  localparam int SHI_HI = 2;
  localparam int SHI_LO = 0;
  localparam int SHI_W  = SHI_HI - SHI_LO + 1;

  // Lower sample bits s[6:0] inside the low byte
  localparam int SLO_W = 7;

  // Full sample width
  localparam int SAMPLE_W = SHI_W + SLO_W;

  // Width of the saturating framing-error counter
  localparam int ERR_CNT_W = 8;

  // True when the byte carries the header marker
  function automatic logic is_header(input logic [7:0] b);
    return b[MARKER_BIT];
  endfunction

endpackage

// File: rtl/adc_frame_decoder.sv
// Two-byte ADC frame decoder. A header byte carries the channel and the
// top three sample bits; the following low byte carries the remaining
// seven bits. Framing problems (stray low bytes, a header while another
// header is pending, an out-of-range channel, or a header that is not
// followed by its low byte in time) each produce a one-cycle frame_err
// pulse and bump a saturating error counter.
module adc_frame_decoder
  import adc_frame_decoder_pkg::*;
#(
  parameter int NUM_CH  = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 new_sample,
  output logic [SAMPLE_W-1:0]  sample,
  output logic [CH_W-1:0]      sample_channel,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // The timer only ever needs to hold values up to TIMEOUT-1
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t               state;
  logic [TMR_W-1:0]     timer;
  logic [CH_W-1:0]      ch_lat;
  logic [SHI_W-1:0]     shi_lat;

  logic                 hdr_byte;
  logic                 lo_byte;
  logic                 ch_ok;
  logic                 frame_ok;
  logic                 timeout_hit;
  logic                 err_event;

  // Classify the current cycle: good frame completion, or any framing error
  always_comb begin
    hdr_byte    = byte_valid && is_header(byte_data);
    lo_byte     = byte_valid && !is_header(byte_data);
    ch_ok       = int'(ch_lat) < NUM_CH;
    frame_ok    = (state == WAIT_LO) && lo_byte && ch_ok;
    timeout_hit = (state == WAIT_LO) && !byte_valid && (timer == TMR_LAST);
    err_event   = ((state == IDLE)    && lo_byte)
               || ((state == WAIT_LO) && hdr_byte)
               || ((state == WAIT_LO) && lo_byte && !ch_ok)
               || timeout_hit;
  end

  // Decoder FSM with header latch, idle timer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      timer          <= '0;
      ch_lat         <= '0;
      shi_lat        <= '0;
      new_sample     <= 1'b0;
      sample         <= '0;
      sample_channel <= '0;
      frame_err      <= 1'b0;
      err_count      <= '0;
    end else begin
      new_sample <= frame_ok;
      frame_err  <= err_event;

      if (err_event && (err_count != ERR_MAX)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end

      if (frame_ok) begin
        sample         <= {shi_lat, byte_data[SLO_W-1:0]};
        sample_channel <= ch_lat;
      end

      case (state)
        IDLE: begin
          if (hdr_byte) begin
            ch_lat  <= byte_data[CH_HI:CH_LO];
            shi_lat <= byte_data[SHI_HI:SHI_LO];
            timer   <= '0;
            state   <= WAIT_LO;
          end
        end

        WAIT_LO: begin
          if (hdr_byte) begin
            ch_lat  <= byte_data[CH_HI:CH_LO];
            shi_lat <= byte_data[SHI_HI:SHI_LO];
            timer   <= '0;
          end else if (lo_byte) begin
            timer <= '0;
            state <= IDLE;
          end else if (timeout_hit) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_decoder.sv
// Self-checking bench for adc_frame_decoder: directed frame scenarios with
// hand-computed values, then randomized byte streams with idle bursts and
// resets, all compared every cycle against a frame-level reference model.
module tb_adc_frame_decoder;

  localparam int NUM_CH  = 10;
  localparam int TIMEOUT = 16;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data  = 8'h00;
  logic       new_sample;
  logic [9:0] sample;
  logic [3:0] sample_channel;
  logic       frame_err;
  logic [7:0] err_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: a pending header (if any) and the expected outputs
  bit have_hdr   = 1'b0;
  int hdr        = 0;
  int idle_run   = 0;
  int exp_cnt    = 0;
  bit exp_ns     = 1'b0;
  bit exp_fe     = 1'b0;
  int exp_sample = 0;
  int exp_ch     = 0;

  always #5 clk = ~clk;

  adc_frame_decoder #(
    .NUM_CH  (NUM_CH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .new_sample     (new_sample),
    .sample         (sample),
    .sample_channel (sample_channel),
    .frame_err      (frame_err),
    .err_count      (err_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit valid, input logic [7:0] data);
    @(posedge clk);
    #1;
    byte_valid = valid;
    byte_data  = data;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Frame-level model: decides what each byte means given whether a header is pending
  always @(posedge clk or negedge rst_n) begin : model
    bit err;
    int ch;
    if (!rst_n) begin
      have_hdr   = 1'b0;
      hdr        = 0;
      idle_run   = 0;
      exp_cnt    = 0;
      exp_ns     = 1'b0;
      exp_fe     = 1'b0;
      exp_sample = 0;
      exp_ch     = 0;
    end else begin
      err    = 1'b0;
      exp_ns = 1'b0;
      if (byte_valid) begin
        if (byte_data >= 8'h80) begin
          err      = have_hdr;
          have_hdr = 1'b1;
          hdr      = int'(byte_data);
          idle_run = 0;
        end else if (!have_hdr) begin
          err = 1'b1;
        end else begin
          have_hdr = 1'b0;
          ch       = (hdr / 8) % 16;
          if (ch < NUM_CH) begin
            exp_ns     = 1'b1;
            exp_ch     = ch;
            exp_sample = (hdr % 8) * 128 + int'(byte_data) % 128;
          end else begin
            err = 1'b1;
          end
        end
      end else if (have_hdr) begin
        idle_run++;
        if (idle_run >= TIMEOUT) begin
          err      = 1'b1;
          have_hdr = 1'b0;
        end
      end
      exp_fe = err;
      if (err && exp_cnt < 255) exp_cnt++;
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    checkOutput("new_sample",     {31'd0, new_sample},     {31'd0, exp_ns});
    checkOutput("frame_err",      {31'd0, frame_err},      {31'd0, exp_fe});
    checkOutput("sample",         {22'd0, sample},         exp_sample);
    checkOutput("sample_channel", {28'd0, sample_channel}, exp_ch);
    checkOutput("err_count",      {24'd0, err_count},      exp_cnt);
    checkOutput("pulse_exclusive", {31'd0, new_sample & frame_err}, 32'd0);
  end

  // Directed scenarios with literal expectations, then randomized traffic
  initial begin
    int burst;
    int r;
    bit last_msb;
    logic [7:0] d;

    $display("[TB] starting adc_frame_decoder bench");
    doReset();

    // Basic frame 0x85, 0x25
    applyStimulus(1'b1, 8'h85);
    applyStimulus(1'b1, 8'h25);
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_basic_ns",     {31'd0, new_sample},     32'd1);
    checkOutput("lit_basic_sample", {22'd0, sample},         32'h2A5);
    checkOutput("lit_basic_ch",     {28'd0, sample_channel}, 32'd0);
    checkOutput("lit_basic_cnt",    {24'd0, err_count},      32'd0);

    // Back-to-back frames without dead cycles
    applyStimulus(1'b1, 8'hAF);
    applyStimulus(1'b1, 8'h7F);
    applyStimulus(1'b1, 8'h85);
    checkOutput("lit_b2b_ns1",     {31'd0, new_sample},     32'd1);
    checkOutput("lit_b2b_sample1", {22'd0, sample},         32'h3FF);
    checkOutput("lit_b2b_ch1",     {28'd0, sample_channel}, 32'd5);
    applyStimulus(1'b1, 8'h25);
    checkOutput("lit_b2b_gap",     {31'd0, new_sample},     32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_b2b_ns2",     {31'd0, new_sample},     32'd1);
    checkOutput("lit_b2b_sample2", {22'd0, sample},         32'h2A5);
    checkOutput("lit_b2b_ch2",     {28'd0, sample_channel}, 32'd0);

    // Stray byte in IDLE, then a normal frame
    doReset();
    applyStimulus(1'b1, 8'h12);
    applyStimulus(1'b1, 8'h85);
    checkOutput("lit_stray_fe",  {31'd0, frame_err},  32'd1);
    checkOutput("lit_stray_cnt", {24'd0, err_count},  32'd1);
    applyStimulus(1'b1, 8'h25);
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_stray_ns",     {31'd0, new_sample}, 32'd1);
    checkOutput("lit_stray_sample", {22'd0, sample},     32'h2A5);

    // Resync: a second header replaces the pending one
    doReset();
    applyStimulus(1'b1, 8'h85);
    applyStimulus(1'b1, 8'hAF);
    applyStimulus(1'b1, 8'h7F);
    checkOutput("lit_resync_fe", {31'd0, frame_err}, 32'd1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_resync_ns",     {31'd0, new_sample},     32'd1);
    checkOutput("lit_resync_sample", {22'd0, sample},         32'h3FF);
    checkOutput("lit_resync_ch",     {28'd0, sample_channel}, 32'd5);

    // Timeout after TIMEOUT idle cycles, then a late low byte is stray
    doReset();
    applyStimulus(1'b1, 8'h85);
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput("lit_timeout_early", {31'd0, frame_err}, 32'd0);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_timeout_fe",  {31'd0, frame_err}, 32'd1);
    checkOutput("lit_timeout_cnt", {24'd0, err_count}, 32'd1);
    applyStimulus(1'b1, 8'h25);
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_late_fe",  {31'd0, frame_err}, 32'd1);
    checkOutput("lit_late_cnt", {24'd0, err_count}, 32'd2);

    // Out-of-range channel 12 leaves the sample untouched
    doReset();
    applyStimulus(1'b1, 8'h85);
    applyStimulus(1'b1, 8'h25);
    applyStimulus(1'b1, 8'hE0);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_badch_fe",     {31'd0, frame_err},  32'd1);
    checkOutput("lit_badch_ns",     {31'd0, new_sample}, 32'd0);
    checkOutput("lit_badch_sample", {22'd0, sample},     32'h2A5);

    // Error counter saturation
    doReset();
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'h12);
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_saturate", {24'd0, err_count}, 32'd255);

    // Reset mid-frame drops the header silently
    doReset();
    applyStimulus(1'b1, 8'h85);
    doReset();
    applyStimulus(1'b1, 8'h25);
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_rstmid_fe",  {31'd0, frame_err},  32'd1);
    checkOutput("lit_rstmid_ns",  {31'd0, new_sample}, 32'd0);
    checkOutput("lit_rstmid_cnt", {24'd0, err_count},  32'd1);

    // Randomized traffic with idle bursts and occasional resets
    last_msb = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 5) begin
        doReset();
      end else if (r < 30) begin
        burst = int'($urandom_range(8, TIMEOUT + 4));
        for (int j = 0; j < burst; j++) applyStimulus(1'b0, 8'($urandom));
      end else if (r < 650) begin
        d = 8'($urandom);
        d[7] = ($urandom_range(0, 9) < 8) ? ~last_msb : last_msb;
        last_msb = d[7];
        applyStimulus(1'b1, d);
      end else begin
        applyStimulus(1'b0, 8'($urandom));
      end
    end

    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
